// File: rtl/trap_seq.sv
// Machine-mode trap sequencer: walks ecall/mret through the CSR updates one
// write per cycle, stalling the pipeline and redirecting fetch at the end.
module trap_seq #(
  parameter int unsigned         XLEN        = 32,
  parameter int unsigned         CSR_AW      = 12,
  parameter logic [XLEN-1:0]     ECALL_CAUSE = 32'hb
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              W_valid_i,
  input  logic              W_ecall_i,
  input  logic              W_mret_i,
  input  logic [XLEN-1:0]   W_pc_i,
  input  logic [XLEN-1:0]   csr_rdata_i,
  output logic [CSR_AW-1:0] csr_raddr_o,
  output logic              csr_we_o,
  output logic [CSR_AW-1:0] csr_waddr_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic              stall_o,
  output logic              flush_o,
  output logic              redirect_valid_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic              busy_o
);

  localparam logic [CSR_AW-1:0] CSR_MSTATUS = CSR_AW'(12'h300);
  localparam logic [CSR_AW-1:0] CSR_MTVEC   = CSR_AW'(12'h305);
  localparam logic [CSR_AW-1:0] CSR_MEPC    = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = CSR_AW'(12'h342);

  typedef enum logic [2:0] {
    IDLE,
    SAVE_EPC,
    SAVE_CAUSE,
    SAVE_STATUS,
    JUMP_TVEC,
    RESTORE_STATUS,
    JUMP_EPC
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   epc_q, epc_d;
  logic              take_ecall, take_mret;
  logic [XLEN-1:0]   status_trap, status_ret;

  // A trigger seen while reset is asserted must not leak flush/stall.
  assign take_ecall = rst_n && (state_q == IDLE) && W_valid_i && W_ecall_i;
  assign take_mret  = rst_n && (state_q == IDLE) && W_valid_i && W_mret_i && !W_ecall_i;

  always_comb begin
    status_trap        = csr_rdata_i;
    status_trap[7]     = csr_rdata_i[3];
    status_trap[3]     = 1'b0;
    status_trap[12:11] = 2'b11;

    status_ret         = csr_rdata_i;
    status_ret[3]      = csr_rdata_i[7];
    status_ret[7]      = 1'b1;
    status_ret[12:11]  = 2'b11;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q <= IDLE;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    epc_d            = epc_q;
    csr_raddr_o      = '0;
    csr_we_o         = 1'b0;
    csr_waddr_o      = '0;
    csr_wdata_o      = '0;
    stall_o          = 1'b1;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    busy_o           = 1'b1;

    unique case (state_q)
      IDLE: begin
        busy_o  = 1'b0;
        stall_o = take_ecall || take_mret;
        flush_o = take_ecall || take_mret;
        if (take_ecall) begin
          state_d = SAVE_EPC;
          epc_d   = W_pc_i;
        end else if (take_mret) begin
          state_d = RESTORE_STATUS;
        end
      end
      SAVE_EPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = epc_q;
        state_d     = SAVE_CAUSE;
      end
      SAVE_CAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = ECALL_CAUSE;
        state_d     = SAVE_STATUS;
      end
      SAVE_STATUS: begin
        csr_raddr_o = CSR_MSTATUS;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = status_trap;
        state_d     = JUMP_TVEC;
      end
      JUMP_TVEC: begin
        csr_raddr_o      = CSR_MTVEC;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = {csr_rdata_i[XLEN-1:2], 2'b00};
        state_d          = IDLE;
      end
      RESTORE_STATUS: begin
        csr_raddr_o = CSR_MSTATUS;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = status_ret;
        state_d     = JUMP_EPC;
      end
      JUMP_EPC: begin
        csr_raddr_o      = CSR_MEPC;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = {csr_rdata_i[XLEN-1:2], 2'b00};
        state_d          = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_trap_seq.sv
// Directed vector bench for trap_seq: each record holds one cycle's inputs and
// the outputs expected in that cycle, plus a hand-written abort sequence.
module tb_trap_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        W_valid_i, W_ecall_i, W_mret_i;
  logic [31:0] W_pc_i, csr_rdata_i;
  logic [11:0] csr_raddr_o, csr_waddr_o;
  logic        csr_we_o, stall_o, flush_o, redirect_valid_o, busy_o;
  logic [31:0] csr_wdata_o, redirect_pc_o;

  int ncmp = 0;
  int nerr = 0;

  trap_seq #(.XLEN(32), .CSR_AW(12), .ECALL_CAUSE(32'hb)) dut (
    .clk_i(clk), .rst_n(rst_n),
    .W_valid_i(W_valid_i), .W_ecall_i(W_ecall_i), .W_mret_i(W_mret_i),
    .W_pc_i(W_pc_i), .csr_rdata_i(csr_rdata_i),
    .csr_raddr_o(csr_raddr_o), .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o),
    .csr_wdata_o(csr_wdata_o), .stall_o(stall_o), .flush_o(flush_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, v, e, m;
    logic [31:0] pc, rd;
    logic        st, fl, bz, we;
    logic [11:0] wa;
    logic [31:0] wd;
    logic [11:0] ra;
    logic        rv;
    logic [31:0] rp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic v, logic e, logic m,
                              logic [31:0] pc, logic [31:0] rd,
                              logic st, logic fl, logic bz, logic we,
                              logic [11:0] wa, logic [31:0] wd, logic [11:0] ra,
                              logic rv, logic [31:0] rp);
    vec_t t;
    t.rst = rst; t.v = v; t.e = e; t.m = m; t.pc = pc; t.rd = rd;
    t.st = st; t.fl = fl; t.bz = bz; t.we = we; t.wa = wa; t.wd = wd;
    t.ra = ra; t.rv = rv; t.rp = rp;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic e, input logic m,
                       input logic [31:0] pc, input logic [31:0] rd);
    rst_n = r; W_valid_i = v; W_ecall_i = e; W_mret_i = m;
    W_pc_i = pc; csr_rdata_i = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rst v e m pc rd | stall flush busy we waddr wdata raddr rv rpc
  initial begin
    // reset then idle
    tbl.push_back(mk(0,0,0,0,32'h0,32'h0,          0,0,0,0,12'h000,32'h0,12'h000,0,32'h0));
    tbl.push_back(mk(1,0,0,0,32'h0,32'h0,          0,0,0,0,12'h000,32'h0,12'h000,0,32'h0));
    // ecall sequence
    tbl.push_back(mk(1,1,1,0,32'h8000_0100,32'h0,  1,1,0,0,12'h000,32'h0,12'h000,0,32'h0));
    tbl.push_back(mk(1,0,0,0,32'h0,32'h0,          1,0,1,1,12'h341,32'h8000_0100,12'h000,0,32'h0));
    tbl.push_back(mk(1,0,0,0,32'h0,32'h0,          1,0,1,1,12'h342,32'h0000_000b,12'h000,0,32'h0));
    tbl.push_back(mk(1,0,0,0,32'h0,32'h1808,       1,0,1,1,12'h300,32'h0000_1880,12'h300,0,32'h0));
    tbl.push_back(mk(1,0,0,0,32'h0,32'h8000_0004,  1,0,1,0,12'h000,32'h0,12'h305,1,32'h8000_0004));
    tbl.push_back(mk(1,0,0,0,32'h0,32'h0,          0,0,0,0,12'h000,32'h0,12'h000,0,32'h0));
    // mret sequence
    tbl.push_back(mk(1,1,0,1,32'h1234_5678,32'h0,  1,1,0,0,12'h000,32'h0,12'h000,0,32'h0));
    tbl.push_back(mk(1,0,0,0,32'h0,32'h1880,       1,0,1,1,12'h300,32'h0000_1888,12'h300,0,32'h0));
    tbl.push_back(mk(1,0,0,0,32'h0,32'h8000_0104,  1,0,1,0,12'h000,32'h0,12'h341,1,32'h8000_0104));
    tbl.push_back(mk(1,0,0,0,32'h0,32'h0,          0,0,0,0,12'h000,32'h0,12'h000,0,32'h0));
    // ecall+mret together acts as ecall; stray triggers mid-sequence ignored
    tbl.push_back(mk(1,1,1,1,32'h8000_0200,32'h0,  1,1,0,0,12'h000,32'h0,12'h000,0,32'h0));
    tbl.push_back(mk(1,1,0,1,32'hdead_beef,32'h0,  1,0,1,1,12'h341,32'h8000_0200,12'h000,0,32'h0));
    tbl.push_back(mk(1,1,1,0,32'hdead_beef,32'h0,  1,0,1,1,12'h342,32'h0000_000b,12'h000,0,32'h0));
    tbl.push_back(mk(1,0,0,0,32'h0,32'h0,          1,0,1,1,12'h300,32'h0000_1800,12'h300,0,32'h0));
    tbl.push_back(mk(1,0,0,0,32'h0,32'h8000_0007,  1,0,1,0,12'h000,32'h0,12'h305,1,32'h8000_0004));
    // back-to-back mret at T+5
    tbl.push_back(mk(1,1,0,1,32'h0,32'h0,          1,1,0,0,12'h000,32'h0,12'h000,0,32'h0));
    tbl.push_back(mk(1,0,0,0,32'h0,32'h0000_0008,  1,0,1,1,12'h300,32'h0000_1880,12'h300,0,32'h0));
    tbl.push_back(mk(1,0,0,0,32'h0,32'h8000_0203,  1,0,1,0,12'h000,32'h0,12'h341,1,32'h8000_0200));
    tbl.push_back(mk(1,0,0,0,32'h0,32'h0,          0,0,0,0,12'h000,32'h0,12'h000,0,32'h0));
    // valid low masks both flags
    tbl.push_back(mk(1,0,1,1,32'h8000_0300,32'h0,  0,0,0,0,12'h000,32'h0,12'h000,0,32'h0));
    tbl.push_back(mk(1,0,0,0,32'h0,32'h0,          0,0,0,0,12'h000,32'h0,12'h000,0,32'h0));
    // reset during SAVE_CAUSE aborts the sequence
    tbl.push_back(mk(1,1,1,0,32'h8000_0400,32'h0,  1,1,0,0,12'h000,32'h0,12'h000,0,32'h0));
    tbl.push_back(mk(1,0,0,0,32'h0,32'h0,          1,0,1,1,12'h341,32'h8000_0400,12'h000,0,32'h0));
    tbl.push_back(mk(0,0,0,0,32'h0,32'h0,          1,0,1,1,12'h342,32'h0000_000b,12'h000,0,32'h0));
    tbl.push_back(mk(1,0,0,0,32'h0,32'h1808,       0,0,0,0,12'h000,32'h0,12'h000,0,32'h0));
    tbl.push_back(mk(1,0,0,0,32'h0,32'h8000_0004,  0,0,0,0,12'h000,32'h0,12'h000,0,32'h0));
    // trigger under reset is ignored
    tbl.push_back(mk(0,1,1,0,32'h8000_0500,32'h0,  0,0,0,0,12'h000,32'h0,12'h000,0,32'h0));
    tbl.push_back(mk(1,0,0,0,32'h0,32'h0,          0,0,0,0,12'h000,32'h0,12'h000,0,32'h0));

    drive(0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].e, tbl[i].m, tbl[i].pc, tbl[i].rd);
      #3;
      chk("stall",    i, 32'(stall_o),          32'(tbl[i].st));
      chk("flush",    i, 32'(flush_o),          32'(tbl[i].fl));
      chk("busy",     i, 32'(busy_o),           32'(tbl[i].bz));
      chk("we",       i, 32'(csr_we_o),         32'(tbl[i].we));
      chk("waddr",    i, 32'(csr_waddr_o),      32'(tbl[i].wa));
      chk("wdata",    i, csr_wdata_o,           tbl[i].wd);
      chk("raddr",    i, 32'(csr_raddr_o),      32'(tbl[i].ra));
      chk("redir_v",  i, 32'(redirect_valid_o), 32'(tbl[i].rv));
      chk("redir_pc", i, redirect_pc_o,         tbl[i].rp);
      tick();
    end

    // Reset landing on SAVE_STATUS: nothing of the sequence may surface later.
    drive(1, 1, 1, 0, 32'h8000_0600, 32'h0);
    tick();
    drive(1, 0, 0, 0, 32'h0, 32'h1808);
    tick();
    tick();
    #3;
    chk("abort_in_status", 0, 32'(csr_raddr_o), 32'h300);
    drive(0, 0, 0, 0, 32'h0, 32'h1808);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 0, 32'h0, 32'h8000_0004);
      #3;
      chk("abort_we",   k, 32'(csr_we_o),         32'h0);
      chk("abort_rv",   k, 32'(redirect_valid_o), 32'h0);
      chk("abort_busy", k, 32'(busy_o),           32'h0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/trap_seq.md
TRAP_SEQ -- requirements
Module: trap_seq

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- XLEN, 32, data/PC width
- CSR_AW, 12, CSR address width
- ECALL_CAUSE, 32'hb, mcause value written on ecall
REQ-002 The block SHALL have these ports (name direction width meaning):
- clk_i  in  1  single clock
- rst_n  in  1  reset; synchronous, active-low
- W_valid_i  in  1  write-back stage holds a valid instruction
- W_ecall_i  in  1  that instruction is ecall
- W_mret_i  in  1  that instruction is mret
- W_pc_i  in  XLEN  PC of that instruction
- csr_rdata_i  in  XLEN  combinational CSR read data for csr_raddr_o
- csr_raddr_o  out  CSR_AW  CSR read address
- csr_we_o  out  1  CSR write enable
- csr_waddr_o  out  CSR_AW  CSR write address
- csr_wdata_o  out  XLEN  CSR write data
- stall_o  out  1  freeze fetch through write-back
- flush_o  out  1  kill all younger in-flight instructions
- redirect_valid_o  out  1  fetch PC redirect strobe
- redirect_pc_o  out  XLEN  redirect target
- busy_o  out  1  FSM not in IDLE

Function
REQ-003 FSM states SHALL be IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, JUMP_TVEC, RESTORE_STATUS, JUMP_EPC; one state per cycle, no waits.
REQ-004 Trigger: in IDLE, W_valid_i=1 with W_ecall_i=1 SHALL go to SAVE_EPC and latch W_pc_i; with W_mret_i=1 (ecall=0) SHALL go to RESTORE_STATUS.
REQ-005 ecall=mret=1 in the same cycle SHALL be treated as ecall only; W_valid_i=0 SHALL ignore both flags.
REQ-006 Triggers arriving while not in IDLE SHALL be ignored (stall_o holds the pipeline, so none are legal).
REQ-007 Trigger cycle: stall_o=1 and flush_o=1 combinationally; flush_o SHALL be 1 only in the trigger cycle.
REQ-008 stall_o SHALL be 1 in the trigger cycle and in every non-IDLE state; busy_o SHALL be 1 exactly in non-IDLE states.
REQ-009 SAVE_EPC: csr_we_o=1, waddr=12'h341, wdata=latched PC.
REQ-010 SAVE_CAUSE: csr_we_o=1, waddr=12'h342, wdata=ECALL_CAUSE.
REQ-011 SAVE_STATUS: raddr=12'h300; we=1, waddr=12'h300, wdata=rdata with bit7(MPIE)=rdata bit3, bit3(MIE)=0, bits12:11(MPP)=2'b11, other bits unchanged.
REQ-012 JUMP_TVEC: raddr=12'h305; redirect_valid_o=1, redirect_pc_o={rdata[XLEN-1:2],2'b00} (direct mode only); next state IDLE.
REQ-013 RESTORE_STATUS: raddr=12'h300; we=1, waddr=12'h300, wdata=rdata with bit3=rdata bit7, bit7=1, bits12:11=2'b11, other bits unchanged.
REQ-014 JUMP_EPC: raddr=12'h341; redirect_valid_o=1, redirect_pc_o={rdata[XLEN-1:2],2'b00}; next state IDLE.
REQ-015 Latency: ecall trigger at cycle T SHALL redirect in T+4; mret trigger at T SHALL redirect in T+2; a new trigger SHALL be accepted from T+5 / T+3.
REQ-016 Outside the states named above, csr_we_o, redirect_valid_o SHALL be 0 and csr_waddr_o, csr_wdata_o, redirect_pc_o, csr_raddr_o SHALL be 0.
REQ-017 At most one CSR write per cycle; no write SHALL occur in IDLE, JUMP_TVEC or JUMP_EPC.

Reset
REQ-018 rst_n=0 at a clock edge SHALL force IDLE and clear the latched PC; all outputs SHALL be 0 in the following cycle.
REQ-019 Reset mid-sequence SHALL abort it; no remaining CSR write or redirect of that sequence SHALL occur.
REQ-020 A trigger present in a cycle where rst_n=0 SHALL be ignored.

Verification
REQ-021 ecall, W_pc_i=32'h8000_0100, mstatus=32'h1808, mtvec=32'h8000_0004 -> T: flush=1, stall=1; T+1 write 341<=8000_0100; T+2 write 342<=0000_000b; T+3 write 300<=0000_1880; T+4 redirect 8000_0004.
REQ-022 mret, mstatus=32'h1880, mepc=32'h8000_0104 -> T+1 write 300<=0000_1888; T+2 redirect 8000_0104; busy_o low at T+3.
REQ-023 ecall=mret=1, valid=1 -> ecall sequence exactly as REQ-021; W_valid_i=0 with ecall=1 -> no stall, flush, write or redirect.
REQ-024 rst_n=0 during SAVE_CAUSE -> next cycle IDLE, all outputs 0; no mstatus write or redirect afterwards.
REQ-025 mtvec=32'h8000_0007 -> redirect_pc_o=32'h8000_0004; back-to-back ecall then mret (second trigger at T+5) -> both sequences complete with correct values.
